irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl_pkg.sv | 22 ++
 rtl/irq_prio_arb.sv | 57 +++++
 rtl/irq_ctrl.sv | 147 ++++++++++++++
 tb/tb_irq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared definitions for the interrupt controller:
//   - state_t : handshake FSM states (IDLE, PRESENT, SERVICE)
//   - id_w()  : width of an interrupt index for n sources, never below 1
//   - MAX_SRC : largest supported number of interrupt sources
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

  localparam int MAX_SRC = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } state_t;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// -----------------------------------------------------------------------------
// irq_prio_arb
// Combinational arbiter that picks one interrupt source from the candidate
// vector.
//   Default build     : fixed priority, where the highest set index wins and
//                       last_id is ignored.
//   IRQ_CTRL_RR_EN    : round robin. The search runs circularly downward from
//                       last_id-1, which makes the most recently granted
//                       source the lowest priority.
// Ports:
//   cand      in  NUM_SRC  pending & ~mask
//   last_id   in  ID_W     index of the most recently acknowledged source
//   sel_id    out ID_W     selected index (0 when nothing is selected)
//   sel_valid out 1        at least one candidate exists
// -----------------------------------------------------------------------------
module irq_prio_arb
  import irq_ctrl_pkg::*;
#(
  parameter  int NUM_SRC = 8,
  localparam int ID_W    = id_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] cand,
  input  logic [ID_W-1:0]    last_id,
  output logic [ID_W-1:0]    sel_id,
  output logic               sel_valid
);

  assign sel_valid = |cand;

`ifdef IRQ_CTRL_RR_EN
  // The loop walks from the farthest offset to the nearest one, so the last
  // hit to be written is the source closest below last_id. Offset NUM_SRC
  // maps back onto last_id itself, so that source is searched last.
  always_comb begin
    int idx;
    idx    = 0;
    sel_id = '0;
    for (int off = NUM_SRC; off >= 1; off--) begin
      idx = int'(last_id) + NUM_SRC - off;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (cand[idx]) sel_id = ID_W'(idx);
    end
  end
`else
  logic unused_last_id;
  assign unused_last_id = ^last_id;

  // Ascending scan: the last assignment comes from the highest set index.
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i]) sel_id = ID_W'(i);
    end
  end
`endif

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Parametrised interrupt controller. Rising edges on irq_req are latched into
// a pending register. Masked sources still become pending, but they are not
// eligible for selection. The winning source is presented to the handler
// through a registered claim (irq_ack) and end-of-interrupt (eoi) handshake.
// The optional macro IRQ_CTRL_RR_EN selects round-robin arbitration instead of
// fixed priority, where the highest index wins.
// Ports:
//   clk         in  1        clock
//   rst_n       in  1        synchronous active-low reset
//   irq_req     in  NUM_SRC  interrupt lines; a rising edge is a request
//   mask_we     in  1        mask write strobe
//   mask_wdata  in  NUM_SRC  new mask value (1 = disabled)
//   irq_valid   out 1        interrupt presented
//   irq_id      out ID_W     presented source index
//   irq_ack     in  1        handler claims the presented interrupt
//   eoi         in  1        handler has finished servicing
//   busy        out 1        an interrupt is in service
//   pending     out NUM_SRC  pending register
//   mask        out NUM_SRC  mask register
// -----------------------------------------------------------------------------
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter  int NUM_SRC = 8,
  localparam int ID_W    = id_w(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               busy,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               irq_valid_q, irq_valid_d;
  logic               busy_q, busy_d;

  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] cand;
  logic [ID_W-1:0]    sel_id;
  logic               sel_valid;
  logic [ID_W-1:0]    last_id;
  logic               ack_taken;

  assign set_vec   = irq_req & ~irq_prev_q;
  assign cand      = pending_q & ~mask_q;
  assign ack_taken = (state_q == PRESENT) && irq_ack;

  irq_prio_arb #(.NUM_SRC(NUM_SRC)) u_arb (
    .cand      (cand),
    .last_id   (last_id),
    .sel_id    (sel_id),
    .sel_valid (sel_valid)
  );

`ifdef IRQ_CTRL_RR_EN
  logic [ID_W-1:0] last_id_q, last_id_d;

  assign last_id_d = ack_taken ? irq_id_q : last_id_q;
  assign last_id   = last_id_q;

  always_ff @(posedge clk) begin
    if (!rst_n) last_id_q <= ID_W'(NUM_SRC - 1);
    else        last_id_q <= last_id_d;
  end
`else
  assign last_id = '0;
`endif

  // NOTE: every signal written here receives a default assignment first, so
  // no path through the case statement can infer a latch.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    clr_vec  = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          irq_id_d = sel_id;
          state_d  = PRESENT;
        end
      end
      // irq_id is frozen here. Mask writes and new arrivals cannot change it.
      // An ack takes precedence over a simultaneous eoi.
      PRESENT: begin
        if (irq_ack) begin
          clr_vec[irq_id_q] = 1'b1;
          state_d           = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // OR-ing the set vector last means a new edge wins over a same-cycle clear.
    pending_d   = (pending_q & ~clr_vec) | set_vec;
    mask_d      = mask_we ? mask_wdata : mask_q;
    irq_prev_d  = irq_req;
    irq_valid_d = (state_d == PRESENT);
    busy_d      = (state_d == SERVICE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values no matter what order the statements are in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      mask_q      <= '1;
      irq_prev_q  <= '0;
      irq_id_q    <= '0;
      irq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      irq_prev_q  <= irq_prev_d;
      irq_id_q    <= irq_id_d;
      irq_valid_q <= irq_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign mask      = mask_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
// Self-checking bench for irq_ctrl with NUM_SRC=8. The expected interrupt ids
// are pushed to a scoreboard queue when stimulus is driven. Each entry is
// popped and compared when the DUT presents an interrupt. Status outputs are
// compared against constants at fixed points in each scenario.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = id_w(NUM_SRC);

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_SRC-1:0] irq_req;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               irq_valid;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic               eoi;
  logic               busy;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_q[$];

  irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_req    (irq_req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .busy       (busy),
    .pending    (pending),
    .mask       (mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move one cycle ahead and settle 1 time unit past the edge. Both sampling
  // and driving happen there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic write_mask(input logic [NUM_SRC-1:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    step();
    mask_we    = 1'b0;
  endtask

  // Wait a bounded number of cycles for irq_valid, then compare irq_id against
  // the next scoreboard entry.
  task automatic expect_present(input string tag);
    int exp_id;
    int waited;
    waited = 0;
    while (!irq_valid && waited < 20) begin
      step();
      waited++;
    end
    check({tag, "_valid"}, irq_valid, 1'b1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s_scoreboard: got an empty queue, expected an entry", tag);
    end else begin
      exp_id = exp_q.pop_front();
      check({tag, "_id"}, irq_id, exp_id[ID_W-1:0]);
    end
  endtask

  task automatic do_ack(input string tag);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check({tag, "_ack_busy"}, busy, 1'b1);
    check({tag, "_ack_valid"}, irq_valid, 1'b0);
  endtask

  task automatic do_eoi(input string tag);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    check({tag, "_eoi_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    irq_req    = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    irq_ack    = 1'b0;
    eoi        = 1'b0;

    // Reset state
    step();
    step();
    rst_n = 1'b1;
    check("rst_valid",   irq_valid, 1'b0);
    check("rst_id",      irq_id,    '0);
    check("rst_busy",    busy,      1'b0);
    check("rst_pending", pending,   8'h00);
    check("rst_mask",    mask,      8'hFF);

    // ack and eoi in IDLE with nothing pending are ignored
    write_mask(8'h00);
    check("mask_wr", mask, 8'h00);
    irq_ack = 1'b1;
    eoi     = 1'b1;
    step();
    irq_ack = 1'b0;
    eoi     = 1'b0;
    check("idle_ign_busy",  busy,      1'b0);
    check("idle_ign_valid", irq_valid, 1'b0);

    // Single source: latency, then ack and eoi together (only the ack is taken)
    irq_req[3] = 1'b1;
    step();
    check("lat_pending", pending,   8'h08);
    check("lat_valid0",  irq_valid, 1'b0);
    exp_q.push_back(3);
    step();
    check("lat_valid1", irq_valid, 1'b1);
    expect_present("t1");
    irq_ack = 1'b1;
    eoi     = 1'b1;
    step();
    irq_ack = 1'b0;
    eoi     = 1'b0;
    check("t1_ackeoi_busy", busy,    1'b1);
    check("t1_ack_pending", pending, 8'h00);
    do_eoi("t1");
    irq_req = '0;

    // Simultaneous rises on bits 1, 5 and 6: expected order 6, 5, 1
    do_reset();
    write_mask(8'h00);
    irq_req = 8'h62;
    step();
    irq_req = '0;
    exp_q.push_back(6);
    exp_q.push_back(5);
    exp_q.push_back(1);
    expect_present("t2a");
    // Masking while PRESENT must neither withdraw nor change the id
    write_mask(8'hFF);
    check("t2_hold_valid", irq_valid, 1'b1);
    check("t2_hold_id",    irq_id,    3'd6);
    write_mask(8'h00);
    do_ack("t2a");
    do_eoi("t2a");
    expect_present("t2b");
    do_ack("t2b");
    do_eoi("t2b");
    expect_present("t2c");
    do_ack("t2c");
    do_eoi("t2c");

    // Masked sources still latch; unmasking during SERVICE takes effect later
    do_reset();
    write_mask(8'h40);
    irq_req = 8'h44;
    step();
    irq_req = '0;
    check("t3_pending", pending, 8'h44);
    exp_q.push_back(2);
    expect_present("t3a");
    do_ack("t3a");
    write_mask(8'h00);
    check("t3_svc_busy",  busy,      1'b1);
    check("t3_svc_valid", irq_valid, 1'b0);
    do_eoi("t3a");
    exp_q.push_back(6);
    expect_present("t3b");
    do_ack("t3b");
    do_eoi("t3b");

    // A new edge in the ack cycle keeps the bit pending; the source is re-presented
    do_reset();
    write_mask(8'h00);
    irq_req[4] = 1'b1;
    step();
    irq_req[4] = 1'b0;
    exp_q.push_back(4);
    expect_present("t4a");
    irq_ack    = 1'b1;
    irq_req[4] = 1'b1;
    step();
    irq_ack    = 1'b0;
    irq_req[4] = 1'b0;
    check("t4_set_wins", pending, 8'h10);
    check("t4_busy",     busy,    1'b1);
    do_eoi("t4a");
    exp_q.push_back(4);
    expect_present("t4b");
    do_ack("t4b");
    check("t4_cleared", pending, 8'h00);
    do_eoi("t4b");

    // Reset during SERVICE while irq_req[0] is held high
    do_reset();
    write_mask(8'h00);
    irq_req[0] = 1'b1;
    exp_q.push_back(0);
    expect_present("t5a");
    do_ack("t5a");
    rst_n = 1'b0;
    step();
    check("t5_rst_valid",   irq_valid, 1'b0);
    check("t5_rst_id",      irq_id,    '0);
    check("t5_rst_busy",    busy,      1'b0);
    check("t5_rst_pending", pending,   8'h00);
    check("t5_rst_mask",    mask,      8'hFF);
    rst_n = 1'b1;
    step();
    check("t5_edge_pending", pending, 8'h01);
    write_mask(8'h00);
    exp_q.push_back(0);
    expect_present("t5b");
    do_ack("t5b");
    do_eoi("t5b");
    irq_req = '0;

    // Bits 7 and 0 re-raised continuously
    do_reset();
    write_mask(8'h00);
    irq_req = 8'h81;
    step();
    irq_req = '0;
`ifdef IRQ_CTRL_RR_EN
    // Index 7 is searched last after reset, then grants alternate
    exp_q.push_back(0);
    exp_q.push_back(7);
    exp_q.push_back(0);
    exp_q.push_back(7);
`else
    exp_q.push_back(7);
    exp_q.push_back(7);
    exp_q.push_back(7);
    exp_q.push_back(7);
`endif
    for (int r = 0; r < 4; r++) begin
      int g;
      g = exp_q[0];
      expect_present($sformatf("t6r%0d", r));
      do_ack($sformatf("t6r%0d", r));
      irq_req[g] = 1'b1;
      step();
      irq_req = '0;
      do_eoi($sformatf("t6r%0d", r));
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
